// File: rtl/testrig_data_mem_responder_if.sv
// Core data-bus bundle between the core (master) and the TestRIG data-memory
// responder (slave), including the driver's stall inputs and the occupancy monitor.
interface testrig_data_mem_responder_if;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [32:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [32:0] data_rdata_o;
  logic        data_err_o;
  logic [6:0]  data_rdata_intg_o;
  logic        gnt_stall_i;
  logic        resp_stall_i;
  logic [2:0]  outstanding_o;

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
           gnt_stall_i, resp_stall_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
           data_rdata_intg_o, outstanding_o
  );

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
           gnt_stall_i, resp_stall_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
           data_rdata_intg_o, outstanding_o
  );
endinterface

// File: rtl/testrig_data_mem_responder.sv
// Tagged 33-bit data memory for TestRIG: grants core requests, commits writes,
// and returns read data / bus errors in request order through a small FIFO.
module testrig_data_mem_responder #(
  parameter int unsigned DepthWords     = 1024,
  parameter logic [31:0] BaseAddr       = 32'h8000_0000,
  parameter int unsigned MaxOutstanding = 2
) (
  input logic                          clk_i,
  input logic                          rst_i,
  testrig_data_mem_responder_if.slave  bus
);

  localparam int unsigned IdxW      = $clog2(DepthWords);
  localparam int unsigned PtrW      = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [31:0] SpanBytes = 32'(DepthWords * 4);
  localparam logic [2:0]  MaxCount  = 3'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

  logic [32:0]     mem [DepthWords];
  logic [32:0]     fifo_rdata [MaxOutstanding];
  logic            fifo_err [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [2:0]      count;

  logic [31:0]     offset;
  logic            in_range;
  logic [IdxW-1:0] index;
  logic            gnt;
  logic            pop;
  logic [32:0]     push_rdata;
  logic            push_err;

  // Unsigned subtraction makes addresses below BaseAddr wrap to huge offsets,
  // so a single compare covers both ends of the window.
  assign offset   = bus.data_addr_i - BaseAddr;
  assign in_range = offset < SpanBytes;
  assign index    = offset[2 +: IdxW];

  // The full-check uses the registered count only, so a pop in the same cycle
  // never frees a slot for this cycle's grant.
  assign gnt = bus.data_req_i & ~bus.gnt_stall_i & ~rst_i & (count < MaxCount);
  assign pop = (count != 3'd0) & ~bus.resp_stall_i;

  assign push_err   = ~in_range;
  assign push_rdata = (in_range & ~bus.data_we_i) ? mem[index] : '0;

  assign bus.data_gnt_o        = gnt;
  assign bus.data_rvalid_o     = pop;
  assign bus.data_rdata_o      = pop ? fifo_rdata[rd_ptr] : '0;
  assign bus.data_err_o        = pop & fifo_err[rd_ptr];
  assign bus.data_rdata_intg_o = '0;
  assign bus.outstanding_o     = count;

  // Memory survives reset; any partial write strips the capability tag.
  always_ff @(posedge clk_i) begin
    if (gnt && bus.data_we_i && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_be_i[i]) begin
          mem[index][8*i +: 8] <= bus.data_wdata_i[8*i +: 8];
        end
      end
      if (bus.data_be_i == 4'hF) begin
        mem[index][32] <= bus.data_wdata_i[32];
      end else if (bus.data_be_i != 4'h0) begin
        mem[index][32] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt) begin
      fifo_rdata[wr_ptr] <= push_rdata;
      fifo_err[wr_ptr]   <= push_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 3'd0;
    end else begin
      if (gnt) begin
        wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrW'(1);
      end
      case ({gnt, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_testrig_data_mem_responder.sv
// Self-checking bench: directed vector table for the corner cases, then random
// traffic compared cycle-by-cycle against a queue/array reference model.
module tb_testrig_data_mem_responder;

  localparam logic [31:0] Base    = 32'h8000_0000;
  localparam int          Depth   = 1024;
  localparam int          MaxOut  = 2;

  typedef struct {
    logic        rst;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [32:0] wdata;
    logic        gstall;
    logic        rstall;
    logic        expGnt;
    logic        expRvalid;
    logic [32:0] expRdata;
    logic        expErr;
    logic [2:0]  expOut;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [32:0] refMem [Depth];
  logic [33:0] refQ [$];

  logic        sGnt;
  logic        sRvalid;
  logic [32:0] sRdata;
  logic        sErr;
  logic [2:0]  sOut;

  vec_t vecs [$];

  testrig_data_mem_responder_if bus ();

  testrig_data_mem_responder #(
    .DepthWords(Depth),
    .BaseAddr(Base),
    .MaxOutstanding(MaxOut)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Drives one cycle starting at a negedge, checks the DUT against the model
  // mid-cycle, then advances the model across the rising edge.
  task automatic applyStimulus(input logic r, input logic req, input logic we,
                               input logic [3:0] be, input logic [31:0] addr,
                               input logic [32:0] wdata, input logic gstall,
                               input logic rstall);
    logic        eGnt;
    logic        eRvalid;
    logic [33:0] head;
    logic [31:0] off;
    int          idx;
    rst                  = r;
    bus.data_req_i       = req;
    bus.data_we_i        = we;
    bus.data_be_i        = be;
    bus.data_addr_i      = addr;
    bus.data_wdata_i     = wdata;
    bus.gnt_stall_i      = gstall;
    bus.resp_stall_i     = rstall;
    #1;
    eGnt    = req && !gstall && !r && (refQ.size() < MaxOut);
    eRvalid = (refQ.size() > 0) && !rstall;
    head    = eRvalid ? refQ[0] : 34'd0;
    sGnt    = bus.data_gnt_o;
    sRvalid = bus.data_rvalid_o;
    sRdata  = bus.data_rdata_o;
    sErr    = bus.data_err_o;
    sOut    = bus.outstanding_o;
    checkOutput("gnt",         64'(sGnt),    64'(eGnt));
    checkOutput("rvalid",      64'(sRvalid), 64'(eRvalid));
    checkOutput("rdata",       64'(sRdata),  64'(head[32:0]));
    checkOutput("err",         64'(sErr),    64'(head[33]));
    checkOutput("outstanding", 64'(sOut),    64'(refQ.size()));
    checkOutput("rdata_intg",  64'(bus.data_rdata_intg_o), 64'd0);
    @(posedge clk);
    if (r) begin
      refQ.delete();
    end else begin
      if (eRvalid) void'(refQ.pop_front());
      if (eGnt) begin
        off = addr - Base;
        idx = int'(off / 4);
        if (off >= 32'(Depth * 4)) begin
          refQ.push_back({1'b1, 33'd0});
        end else if (we) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) refMem[idx][8*b +: 8] = wdata[8*b +: 8];
          if (be == 4'hF) refMem[idx][32] = wdata[32];
          else if (be != 4'h0) refMem[idx][32] = 1'b0;
          refQ.push_back({1'b0, 33'd0});
        end else begin
          refQ.push_back({1'b0, refMem[idx]});
        end
      end
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic r, input logic req, input logic we,
                              input logic [3:0] be, input logic [31:0] addr,
                              input logic [32:0] wdata, input logic gs, input logic rs,
                              input logic eg, input logic ev, input logic [32:0] ed,
                              input logic ee, input logic [2:0] eo);
    vec_t v;
    v.rst = r; v.req = req; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata;
    v.gstall = gs; v.rstall = rs;
    v.expGnt = eg; v.expRvalid = ev; v.expRdata = ed; v.expErr = ee; v.expOut = eo;
    return v;
  endfunction

  initial begin
    logic [31:0] addr;
    logic [3:0]  be;
    int          sel;

    for (int i = 0; i < Depth; i++) refMem[i] = 33'd0;

    // Directed sequence: reset, tag handling, range errors, stalls, RAW, mid-flight reset.
    vecs.push_back(mk(1,1,1,4'hF,Base,        33'h1_FFFF_FFFF,0,0, 0,0,33'd0,0,3'd0));
    vecs.push_back(mk(0,1,1,4'hF,Base+32'h10, 33'h1_DEAD_BEEF,0,0, 1,0,33'd0,0,3'd0));
    vecs.push_back(mk(0,1,0,4'h0,Base+32'h10, 33'd0,0,0,           1,1,33'd0,0,3'd1));
    vecs.push_back(mk(0,0,0,4'h0,32'd0,       33'd0,0,0,           0,1,33'h1_DEAD_BEEF,0,3'd1));
    vecs.push_back(mk(0,1,1,4'b0010,Base+32'h10,33'h0_0000_5500,0,0,1,0,33'd0,0,3'd0));
    vecs.push_back(mk(0,1,0,4'h0,Base+32'h10, 33'd0,0,0,           1,1,33'd0,0,3'd1));
    vecs.push_back(mk(0,0,0,4'h0,32'd0,       33'd0,0,0,           0,1,33'h0_DEAD_55EF,0,3'd1));
    vecs.push_back(mk(0,1,0,4'h0,32'h7FFF_FFFC,33'd0,0,0,          1,0,33'd0,0,3'd0));
    vecs.push_back(mk(0,1,1,4'hF,Base+32'h1000,33'h1_FFFF_FFFF,0,0,1,1,33'd0,1,3'd1));
    vecs.push_back(mk(0,1,0,4'h0,Base,        33'd0,0,0,           1,1,33'd0,1,3'd1));
    vecs.push_back(mk(0,0,0,4'h0,32'd0,       33'd0,0,0,           0,1,33'h1_0000_A5A5,0,3'd1));
    vecs.push_back(mk(0,1,0,4'h0,Base+32'h10, 33'd0,0,1,           1,0,33'd0,0,3'd0));
    vecs.push_back(mk(0,1,0,4'h0,Base,        33'd0,0,1,           1,0,33'd0,0,3'd1));
    vecs.push_back(mk(0,1,0,4'h0,32'h7FFF_FFFC,33'd0,0,1,          0,0,33'd0,0,3'd2));
    vecs.push_back(mk(0,1,0,4'h0,32'h7FFF_FFFC,33'd0,0,0,          0,1,33'h0_DEAD_55EF,0,3'd2));
    vecs.push_back(mk(0,1,0,4'h0,32'h7FFF_FFFC,33'd0,0,0,          1,1,33'h1_0000_A5A5,0,3'd1));
    vecs.push_back(mk(0,0,0,4'h0,32'd0,       33'd0,0,0,           0,1,33'd0,1,3'd1));
    vecs.push_back(mk(0,1,1,4'hF,Base+32'h20, 33'h0_1234_5678,0,0, 1,0,33'd0,0,3'd0));
    vecs.push_back(mk(0,1,0,4'h0,Base+32'h20, 33'd0,0,0,           1,1,33'd0,0,3'd1));
    vecs.push_back(mk(0,0,0,4'h0,32'd0,       33'd0,0,0,           0,1,33'h0_1234_5678,0,3'd1));
    vecs.push_back(mk(0,1,1,4'h0,Base+32'h20, 33'h1_FFFF_FFFF,0,0, 1,0,33'd0,0,3'd0));
    vecs.push_back(mk(0,1,0,4'h0,Base+32'h20, 33'd0,0,0,           1,1,33'd0,0,3'd1));
    vecs.push_back(mk(0,0,0,4'h0,32'd0,       33'd0,0,0,           0,1,33'h0_1234_5678,0,3'd1));
    vecs.push_back(mk(0,1,0,4'h0,Base+32'h20, 33'd0,1,0,           0,0,33'd0,0,3'd0));
    vecs.push_back(mk(0,0,0,4'h0,32'd0,       33'd0,0,0,           0,0,33'd0,0,3'd0));
    vecs.push_back(mk(0,1,0,4'h0,Base+32'h10, 33'd0,0,1,           1,0,33'd0,0,3'd0));
    vecs.push_back(mk(0,1,0,4'h0,Base,        33'd0,0,1,           1,0,33'd0,0,3'd1));
    vecs.push_back(mk(1,1,1,4'hF,Base+32'h20, 33'h1_AAAA_AAAA,0,1, 0,0,33'd0,0,3'd2));
    vecs.push_back(mk(0,0,0,4'h0,32'd0,       33'd0,0,0,           0,0,33'd0,0,3'd0));
    vecs.push_back(mk(0,0,0,4'h0,32'd0,       33'd0,0,0,           0,0,33'd0,0,3'd0));
    vecs.push_back(mk(0,1,0,4'h0,Base+32'h20, 33'd0,0,0,           1,0,33'd0,0,3'd0));
    vecs.push_back(mk(0,0,0,4'h0,32'd0,       33'd0,0,0,           0,1,33'h0_1234_5678,0,3'd1));

    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = 4'h0;
    bus.data_addr_i  = 32'd0;
    bus.data_wdata_i = 33'd0;
    bus.gnt_stall_i  = 1'b0;
    bus.resp_stall_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] reset released, preloading words 0..15");

    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1, 1, 4'hF, Base + 32'(4 * i),
                    (i == 0) ? 33'h1_0000_A5A5 : {1'($urandom_range(0, 1)), 32'($urandom)}, 0, 0);
    end
    repeat (2) applyStimulus(0, 0, 0, 4'h0, 32'd0, 33'd0, 0, 0);

    $display("[TB] applying %0d directed vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].we, vecs[i].be, vecs[i].addr,
                    vecs[i].wdata, vecs[i].gstall, vecs[i].rstall);
      checkOutput($sformatf("vec%0d.gnt", i),    64'(sGnt),    64'(vecs[i].expGnt));
      checkOutput($sformatf("vec%0d.rvalid", i), 64'(sRvalid), 64'(vecs[i].expRvalid));
      checkOutput($sformatf("vec%0d.rdata", i),  64'(sRdata),  64'(vecs[i].expRdata));
      checkOutput($sformatf("vec%0d.err", i),    64'(sErr),    64'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d.out", i),    64'(sOut),    64'(vecs[i].expOut));
    end

    $display("[TB] random traffic against reference model");
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)
        addr = Base - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
      else if (sel == 1)
        addr = Base + 32'(Depth * 4) + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      else
        addr = Base + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      be = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7),
                    1'($urandom_range(0, 1)), be, addr,
                    {1'($urandom_range(0, 1)), 32'($urandom)},
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 3));
    end

    repeat (4) applyStimulus(0, 0, 0, 4'h0, 32'd0, 33'd0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
